// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: vertical FSM states and default 640x480 timing
// for both axes, so the horizontal and vertical generators start from one source.
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } vstate_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_seg_counter.sv
// Loadable down-counter with a zero flag; tracks how many lines (or pixels)
// remain in the current timing segment.
module vga_seg_counter #(
    parameter int             W       = 10,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic          dec,
    output logic [W-1:0]  count,
    output logic          zero
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/vga_vtiming_gen.sv
// Parametrised vertical timing generator: advances one line per line_tick and
// produces registered v_count, VS, vertical-active and frame/vblank strobes.
module vga_vtiming_gen
    import vga_pkg::*;
#(
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             line_tick,
    input  logic             run,
    input  logic             resync,
    output logic [CNT_W-1:0] v_count,
    output logic             vga_vs,
    output logic             v_active,
    output logic             frame_start,
    output logic             vblank_start
);

    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] LAST_LINE   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] VBLANK_LINE = CNT_W'(V_ACTIVE);

    generate
        if (V_ACTIVE < 1 || V_SYNC < 1 || V_FP < 0 || V_BP < 0 ||
            V_TOTAL > (1 << CNT_W)) begin : g_bad_params
            $error("vga_vtiming_gen: invalid timing parameters or CNT_W too small");
        end
    endgenerate

    // Reload value for a segment is its length minus one; zero-length porches
    // are never entered, so their wrapped value is irrelevant.
    function automatic logic [CNT_W-1:0] seg_len_m1(input vstate_t s);
        case (s)
            ACTIVE:  return CNT_W'(V_ACTIVE - 1);
            FRONT:   return CNT_W'(V_FP - 1);
            SYNC:    return CNT_W'(V_SYNC - 1);
            BACK:    return CNT_W'(V_BP - 1);
            default: return CNT_W'(V_ACTIVE - 1);
        endcase
    endfunction

    vstate_t          state;
    vstate_t          state_after;
    vstate_t          nxt_state;
    logic [CNT_W-1:0] nxt_count;
    logic [CNT_W-1:0] seg_cnt;
    logic             seg_zero;
    logic             resync_pend;
    logic             advance;
    logic             do_resync;
    logic             seg_load;
    logic             seg_dec;

    assign advance   = line_tick & run;
    assign do_resync = resync | resync_pend;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_after = ACTIVE;
        case (state)
            ACTIVE:  state_after = (V_FP > 0) ? FRONT : SYNC;
            FRONT:   state_after = SYNC;
            SYNC:    state_after = (V_BP > 0) ? BACK : ACTIVE;
            BACK:    state_after = ACTIVE;
            default: state_after = ACTIVE;
        endcase
    end

    always_comb begin
        nxt_state = state;
        nxt_count = v_count + 1'b1;
        if (do_resync) begin
            nxt_state = ACTIVE;
            nxt_count = '0;
        end else begin
            if (seg_zero) begin
                nxt_state = state_after;
            end
            if (v_count == LAST_LINE) begin
                nxt_count = '0;
            end
        end
    end

    assign seg_load = advance & (do_resync | seg_zero);
    assign seg_dec  = advance & ~seg_load;

    vga_seg_counter #(
        .W       (CNT_W),
        .RST_VAL (CNT_W'(V_ACTIVE - 1))
    ) u_seg_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (seg_load),
        .load_val (seg_len_m1(nxt_state)),
        .dec      (seg_dec),
        .count    (seg_cnt),
        .zero     (seg_zero)
    );

    // Outputs are computed from the next line so they change together with v_count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ACTIVE;
            v_count      <= '0;
            vga_vs       <= ~VS_POL;
            v_active     <= 1'b1;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            resync_pend  <= 1'b0;
        end else begin
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            if (advance) begin
                state        <= nxt_state;
                v_count      <= nxt_count;
                vga_vs       <= (nxt_state == SYNC) ? VS_POL : ~VS_POL;
                v_active     <= (nxt_state == ACTIVE);
                frame_start  <= (nxt_count == '0);
                vblank_start <= (nxt_count == VBLANK_LINE);
                resync_pend  <= 1'b0;
            end else if (resync) begin
                resync_pend  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_vtiming_gen.sv
// Scoreboard bench for vga_vtiming_gen: a default 640x480 instance and a tiny
// VS_POL=1 instance without front porch share the same stimulus.
module tb_vga_vtiming_gen;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       line_tick;
    logic       run;
    logic       resync;

    logic [9:0] vc0;
    logic       vs0, act0, fs0, vb0;
    logic [2:0] vc1;
    logic       vs1, act1, fs1, vb1;

    always #5 clk = ~clk;

    vga_vtiming_gen u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .line_tick    (line_tick),
        .run          (run),
        .resync       (resync),
        .v_count      (vc0),
        .vga_vs       (vs0),
        .v_active     (act0),
        .frame_start  (fs0),
        .vblank_start (vb0)
    );

    vga_vtiming_gen #(
        .V_ACTIVE (4),
        .V_FP     (0),
        .V_SYNC   (1),
        .V_BP     (2),
        .VS_POL   (1'b1),
        .CNT_W    (3)
    ) u_small (
        .clk          (clk),
        .reset_n      (reset_n),
        .line_tick    (line_tick),
        .run          (run),
        .resync       (resync),
        .v_count      (vc1),
        .vga_vs       (vs1),
        .v_active     (act1),
        .frame_start  (fs1),
        .vblank_start (vb1)
    );

    typedef struct {
        int due;
        int dut;
        int cnt;
        bit vs;
        bit act;
        bit fs;
        bit vb;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fs_seen  = 0;
    int vb_seen  = 0;
    bit seen_front = 1'b0;

    // Reference timing for each instance, indexed by dut number
    int m_a  [2] = '{480, 4};
    int m_fp [2] = '{10, 0};
    int m_s  [2] = '{2, 1};
    int m_bp [2] = '{33, 2};
    bit m_pol[2] = '{1'b0, 1'b1};
    int m_cnt[2] = '{0, 0};
    bit m_pend[2] = '{1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input exp_t e);
        if (e.dut == 0) begin
            check("d0 v_count",      32'(vc0),  32'(e.cnt));
            check("d0 vga_vs",       32'(vs0),  32'(e.vs));
            check("d0 v_active",     32'(act0), 32'(e.act));
            check("d0 frame_start",  32'(fs0),  32'(e.fs));
            check("d0 vblank_start", 32'(vb0),  32'(e.vb));
        end else begin
            check("d1 v_count",      32'(vc1),  32'(e.cnt));
            check("d1 vga_vs",       32'(vs1),  32'(e.vs));
            check("d1 v_active",     32'(act1), 32'(e.act));
            check("d1 frame_start",  32'(fs1),  32'(e.fs));
            check("d1 vblank_start", 32'(vb1),  32'(e.vb));
        end
    endtask

    function automatic exp_t model_out(input int d, input bit fs, input bit vb);
        exp_t e;
        int   sync_lo;
        sync_lo = m_a[d] + m_fp[d];
        e.due = 0;
        e.dut = d;
        e.cnt = m_cnt[d];
        e.vs  = (m_cnt[d] >= sync_lo && m_cnt[d] < sync_lo + m_s[d]) ? m_pol[d] : !m_pol[d];
        e.act = (m_cnt[d] < m_a[d]);
        e.fs  = fs;
        e.vb  = vb;
        return e;
    endfunction

    // Monitor: pops every expectation whose clock edge has happened
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            cmp(e);
        end
        if (reset_n) begin
            fs_seen = fs_seen + int'(fs0);
            vb_seen = vb_seen + int'(vb0);
        end
        if (u_small.state == FRONT) seen_front = 1'b1;
    end

    // One clock of stimulus; expected response is queued for the monitor
    task automatic step(input bit lt, input bit rn, input bit rs);
        exp_t e;
        int   tot;
        bit   fs;
        bit   vb;
        line_tick = lt;
        run       = rn;
        resync    = rs;
        for (int d = 0; d < 2; d++) begin
            tot = m_a[d] + m_fp[d] + m_s[d] + m_bp[d];
            fs  = 1'b0;
            vb  = 1'b0;
            if (lt && rn) begin
                if (rs || m_pend[d]) begin
                    m_cnt[d] = 0;
                end else begin
                    m_cnt[d] = (m_cnt[d] == tot - 1) ? 0 : m_cnt[d] + 1;
                end
                fs = (m_cnt[d] == 0);
                vb = (m_cnt[d] == m_a[d]);
                m_pend[d] = 1'b0;
            end else if (rs) begin
                m_pend[d] = 1'b1;
            end
            e     = model_out(d, fs, vb);
            e.due = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        line_tick = 1'b0;
        resync    = 1'b0;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_pend[d] = 1'b0;
        end
    endtask

    initial begin
        int fs0_base;
        int vb0_base;

        reset_n   = 1'b0;
        line_tick = 1'b0;
        run       = 1'b1;
        resync    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cmp(model_out(0, 1'b0, 1'b0));
        cmp(model_out(1, 1'b0, 1'b0));
        #1 reset_n = 1'b1;

        // No strobe at reset release
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Two full frames with an idle clock between ticks
        fs0_base = fs_seen;
        vb0_base = vb_seen;
        ticks(1050, 1);
        @(negedge clk);
        check("frame_start pulses in 2 frames", 32'(fs_seen - fs0_base), 32'd2);
        check("vblank_start pulses in 2 frames", 32'(vb_seen - vb0_base), 32'd2);
        @(posedge clk);
        #1;

        // Hold with run low while line_tick keeps pulsing
        ticks(100, 0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Resync coincident with line_tick at line 300
        ticks(199, 0);
        step(1'b1, 1'b1, 1'b1);

        // Resync while idle stays pending until the next tick
        ticks(5, 0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // line_tick held high for three clocks
        ticks(3, 0);

        // Asynchronous reset while in sync (line 491)
        ticks(488, 0);
        #5;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async reset v_count", 32'(vc0), 32'd0);
        check("async reset vga_vs",  32'(vs0), 32'd1);
        cmp(model_out(1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);

        // Resync at the last line behaves like a normal wrap
        ticks(523, 0);
        step(1'b1, 1'b1, 1'b1);
        ticks(2, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        check("scoreboard drained", 32'(q.size()), 32'd0);
        check("small instance never in FRONT", 32'(seen_front), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
